// File: rtl/vga_pixel_src_pkg.sv
// vga_pkg: shared constants and types for the vga_pixel_src pixel source.
//   - default visible raster size
//   - game-side register word map
//   - sprite dimension and the packed register-set struct used for both the
//     shadow (game-written) and active (displayed) copies
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int GND_BITS = 320;
  localparam int SPR_DIM  = 16;

  localparam logic [4:0] GND_BASE = 5'd0;
  localparam logic [4:0] SPR_BASE = 5'd10;
  localparam logic [4:0] POS_ADDR = 5'd18;
  localparam logic [4:0] GY_ADDR  = 5'd19;

  // Sprite bitmap: [row][bit], bit 15 is the leftmost pixel of a row.
  typedef logic [SPR_DIM-1:0][SPR_DIM-1:0] spr_bmp_t;

  typedef struct packed {
    logic [GND_BITS-1:0] gnd;
    spr_bmp_t            spr;
    logic [9:0]          sx;
    logic [8:0]          sy;
    logic [8:0]          gy;
  } frame_regs_t;

endpackage

// File: rtl/vga_pixel_src_if.sv
// vga_pixel_src_if: game-side register write port (valid/ready).
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  write accepted when wr_valid & wr_ready
//   wr_addr   master->slave  5-bit register word address
//   wr_data   master->slave  32-bit write data
interface vga_pixel_src_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_sprite_hit.sv
// vga_sprite_hit: combinational 16x16 sprite coverage test.
//   row, col      current pixel
//   spr_x, spr_y  sprite top-left corner
//   bitmap        sprite rows, bit 15 leftmost
//   hit           1 when the pixel lies inside the sprite and its bit is set
// Unsigned wrap of the offsets rejects pixels left of / above the sprite, and
// the sprite is clipped at the raster edge rather than wrapping around.
module vga_sprite_hit
  import vga_pkg::*;
(
  input  logic [8:0] row,
  input  logic [9:0] col,
  input  logic [9:0] spr_x,
  input  logic [8:0] spr_y,
  input  spr_bmp_t   bitmap,
  output logic       hit
);

  localparam logic [9:0] DIM_X = 10'(SPR_DIM);
  localparam logic [8:0] DIM_Y = 9'(SPR_DIM);

  logic [9:0] dx_s;
  logic [8:0] dy_s;

  // Window check and bitmap bit select.
  always_comb begin
    dx_s = col - spr_x;
    dy_s = row - spr_y;
    hit  = 1'b0;
    if ((dx_s < DIM_X) && (dy_s < DIM_Y)) begin
      hit = bitmap[dy_s[3:0]][4'd15 - dx_s[3:0]];
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/vga_pixel_src.sv
// vga_pixel_src: monochrome pixel source for the VGA timing block.
//   vga_clk, rst          25 MHz pixel clock, synchronous active-high reset
//   rdn, row_addr, col_addr  pixel read request (active low) and coordinate
//   vs                    vertical sync (low during lines 0-1)
//   wr                    game-side register write port (vga_pixel_src_if.slave)
//   px, px_valid          pixel (1 = black) one cycle after the read
//   frame_done            one-cycle pulse after each shadow->active commit
// A frame is a 2x-scaled 320-bit ground strip plus one 16x16 sprite. Game
// writes land in shadow registers; the whole set is copied to the active
// registers on the falling edge of vs so a displayed frame never tears.
// Optional build macro VGA_PX_BORDER_EN adds a 1-pixel black frame.
module vga_pixel_src
  import vga_pkg::*;
#(
  parameter int GROUND_H = 8,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic                  vga_clk,
  input  logic                  rst,
  input  logic                  rdn,
  input  logic [8:0]            row_addr,
  input  logic [9:0]            col_addr,
  input  logic                  vs,
  vga_pixel_src_if.slave        wr,
  output logic                  px,
  output logic                  px_valid,
  output logic                  frame_done
);

  localparam logic [9:0] GH_W = 10'(GROUND_H);
  localparam logic [9:0] H_W  = 10'(H_ACTIVE);
  localparam logic [9:0] V_W  = 10'(V_ACTIVE);

  frame_regs_t shadow_q, shadow_d;
  frame_regs_t active_q, active_d;
  logic        vs_q, vs_d;
  logic        rdy_q, rdy_d;
  logic        px_q, px_d;
  logic        px_valid_q, px_valid_d;
  logic        frame_done_q, frame_done_d;

  logic        commit_s;
  logic        wr_fire_s;
  logic        gnd_hit_s;
  logic        spr_hit_s;
  logic        border_s;
  logic [9:0]  row_ext_s;
  logic [9:0]  gy_ext_s;
  logic [8:0]  gnd_base_s;
  logic [3:0]  spr_row_s;

  // Falling edge of vs is the only point where the active set changes.
  assign commit_s    = vs_q & ~vs;
  assign wr.wr_ready = rdy_q & ~commit_s;
  assign wr_fire_s   = wr.wr_valid & wr.wr_ready;
  assign px          = px_q;
  assign px_valid    = px_valid_q;
  assign frame_done  = frame_done_q;

  // Ground word i starts at bit 32i; sprite word k (addr 10+k) holds rows 2k and
  // 2k+1. Since 10 mod 8 = 2, k = addr[2:0] - 2 within the 10..17 range.
  assign gnd_base_s = {wr.wr_addr[3:0], 5'b00000};
  assign spr_row_s  = {wr.wr_addr[2:0] - 3'd2, 1'b0};

  vga_sprite_hit u_sprite_hit (
    .row    (row_addr),
    .col    (col_addr),
    .spr_x  (active_q.sx),
    .spr_y  (active_q.sy),
    .bitmap (active_q.spr),
    .hit    (spr_hit_s)
  );

  // Ground strip hit: row window compared at 10 bits so gy+GROUND_H cannot wrap.
  always_comb begin
    row_ext_s = {1'b0, row_addr};
    gy_ext_s  = {1'b0, active_q.gy};
    gnd_hit_s = 1'b0;
    if ((row_ext_s >= gy_ext_s) && (row_ext_s <= gy_ext_s + GH_W - 10'd1) &&
        (row_ext_s < V_W) && (col_addr < H_W)) begin
      gnd_hit_s = active_q.gnd[col_addr[9:1]];
    end else begin
      gnd_hit_s = 1'b0;
    end
  end

`ifdef VGA_PX_BORDER_EN
  assign border_s = (row_addr == 9'd0) || (row_ext_s == V_W - 10'd1) ||
                    (col_addr == 10'd0) || (col_addr == H_W - 10'd1);
`else
  assign border_s = 1'b0;
`endif

  // Next-state: shadow writes, vs-edge commit, pixel pipeline stage.
  always_comb begin
    vs_d         = vs;
    rdy_d        = 1'b1;
    frame_done_d = commit_s;
    px_valid_d   = ~rdn;
    px_d         = ~rdn & (gnd_hit_s | spr_hit_s | border_s);
    shadow_d     = shadow_q;
    active_d     = active_q;

    if (commit_s) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end

    if (wr_fire_s) begin
      if (wr.wr_addr < SPR_BASE) begin
        shadow_d.gnd[gnd_base_s +: 32] = wr.wr_data;
      end else if (wr.wr_addr < POS_ADDR) begin
        shadow_d.spr[spr_row_s]        = wr.wr_data[15:0];
        shadow_d.spr[spr_row_s | 4'd1] = wr.wr_data[31:16];
      end else if (wr.wr_addr == POS_ADDR) begin
        shadow_d.sx = wr.wr_data[9:0];
        shadow_d.sy = wr.wr_data[18:10];
      end else if (wr.wr_addr == GY_ADDR) begin
        shadow_d.gy = wr.wr_data[8:0];
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      vs_q         <= 1'b0;
      rdy_q        <= 1'b0;
      px_q         <= 1'b0;
      px_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      vs_q         <= vs_d;
      rdy_q        <= rdy_d;
      px_q         <= px_d;
      px_valid_q   <= px_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_src.sv
// tb_vga_pixel_src: self-checking bench for vga_pixel_src. A frame-level model
// (ground bit array, sprite row array, positions; shadow and active copies)
// predicts every pixel from coordinates with plain arithmetic.
module tb_vga_pixel_src;

  logic       vga_clk = 1'b0;
  logic       rst;
  logic       rdn;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       vs;
  logic       px;
  logic       px_valid;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  vga_pixel_src_if wr_if ();

  vga_pixel_src dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .rdn        (rdn),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .vs         (vs),
    .wr         (wr_if),
    .px         (px),
    .px_valid   (px_valid),
    .frame_done (frame_done)
  );

  always #20 vga_clk = ~vga_clk;

  // ---------------- reference model ----------------
  bit          sh_gnd [320];
  bit          a_gnd  [320];
  logic [15:0] sh_spr [16];
  logic [15:0] a_spr  [16];
  int sh_sx, sh_sy, sh_gy;
  int a_sx, a_sy, a_gy;

  function automatic void model_clear();
    for (int i = 0; i < 320; i++) begin sh_gnd[i] = 0; a_gnd[i] = 0; end
    for (int i = 0; i < 16; i++) begin sh_spr[i] = 16'h0; a_spr[i] = 16'h0; end
    sh_sx = 0; sh_sy = 0; sh_gy = 0; a_sx = 0; a_sy = 0; a_gy = 0;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    if (a < 10) begin
      for (int j = 0; j < 32; j++) sh_gnd[32 * a + j] = d[j];
    end else if (a < 18) begin
      sh_spr[2 * (a - 10)]     = d[15:0];
      sh_spr[2 * (a - 10) + 1] = d[31:16];
    end else if (a == 18) begin
      sh_sx = int'(d[9:0]);
      sh_sy = int'(d[18:10]);
    end else if (a == 19) begin
      sh_gy = int'(d[8:0]);
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < 320; i++) a_gnd[i] = sh_gnd[i];
    for (int i = 0; i < 16; i++) a_spr[i] = sh_spr[i];
    a_sx = sh_sx; a_sy = sh_sy; a_gy = sh_gy;
  endfunction

  function automatic logic model_px(input int row, input int col);
    logic h;
    h = 1'b0;
    if (row >= a_gy && row <= a_gy + 8 - 1 && col < 640 && a_gnd[col / 2]) h = 1'b1;
    if (col >= a_sx && col < a_sx + 16 && row >= a_sy && row < a_sy + 16) begin
      if (a_spr[row - a_sy][15 - (col - a_sx)]) h = 1'b1;
    end
`ifdef VGA_PX_BORDER_EN
    if (row == 0 || row == 479 || col == 0 || col == 639) h = 1'b1;
`endif
    return h;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_read(input int row, input int col, input logic rd,
                         output logic p, output logic pv);
    rdn = ~rd;
    row_addr = row[8:0];
    col_addr = col[9:0];
    tick();
    p = px;
    pv = px_valid;
    rdn = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    for (int n = 0; n < 4 && !acc; n++) begin
      #1;
      acc = wr_if.wr_ready;
      @(posedge vga_clk);
      #1;
    end
    wr_if.wr_valid = 1'b0;
    total++;
    if (acc !== 1'b1) begin
      bad++;
      $display("FAIL write_accept addr=%0d got_ready=%b exp=1", a, acc);
    end else begin
      model_write(int'(a), d);
    end
  endtask

  // vs high for a cycle, then low: commit happens at the edge after vs falls.
  task automatic do_commit(output logic rdy_c, output logic fd1, output logic fd2);
    vs = 1'b1;
    tick();
    vs = 1'b0;
    #1;
    rdy_c = wr_if.wr_ready;
    @(posedge vga_clk);
    #1;
    fd1 = frame_done;
    model_commit();
    tick();
    fd2 = frame_done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rdn = 1'b1; row_addr = 9'd0; col_addr = 10'd0; vs = 1'b1;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = 5'd0; wr_if.wr_data = 32'd0;
    tick(); tick(); tick();
    rst = 1'b0; vs = 1'b0;
    model_clear();
    tick();
    total++; if (px !== 1'b0) begin bad++; $display("FAIL reset_px got=%b exp=0", px); end
    total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL reset_px_valid got=%b exp=0", px_valid); end
    total++; if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_if.wr_ready); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_no_frame_done cyc=%0d got=%b exp=0", i, frame_done); end
      tick();
    end
  endtask

  task automatic check_points(input string name, input int rows[], input int cols[]);
    logic p, pv, e;
    for (int i = 0; i < rows.size(); i++) begin
      do_read(rows[i], cols[i], 1'b1, p, pv);
      e = model_px(rows[i], cols[i]);
      total++;
      if (p !== e || pv !== 1'b1) begin
        bad++;
        $display("FAIL %s (%0d,%0d) got px=%b pv=%b exp px=%b pv=1", name, rows[i], cols[i], p, pv, e);
      end
    end
  endtask

  task automatic test_commit_check(input string name);
    logic rc, f1, f2;
    do_commit(rc, f1, f2);
    total++; if (rc !== 1'b0) begin bad++; $display("FAIL %s_ready_in_commit got=%b exp=0", name, rc); end
    total++; if (f1 !== 1'b1) begin bad++; $display("FAIL %s_frame_done got=%b exp=1", name, f1); end
    total++; if (f2 !== 1'b0) begin bad++; $display("FAIL %s_frame_done_len got=%b exp=0", name, f2); end
  endtask

  task automatic test_ground();
    do_write(5'd0, 32'h0000_0001);
    do_write(5'd19, 32'd400);
    test_commit_check("ground");
    check_points("ground", '{400, 400, 400, 408, 407, 399}, '{0, 1, 2, 0, 1, 0});
  endtask

  task automatic test_sprite();
    do_write(5'd10, 32'h0000_8001);
    do_write(5'd18, (32'd50 << 10) | 32'd100);
    test_commit_check("sprite");
    check_points("sprite", '{50, 50, 50, 50, 49, 51}, '{100, 115, 101, 99, 100, 100});
  endtask

  task automatic test_clip();
    do_write(5'd18, (32'd60 << 10) | 32'd630);
    do_write(5'd10, 32'h0000_FFFF);
    test_commit_check("clip");
    check_points("clip", '{60, 60, 60, 60, 61, 61, 60}, '{629, 630, 635, 639, 0, 1, 0});
  endtask

  task automatic test_shadow_hold();
    logic r0, r1, fd, p, pv;
    do_write(5'd18, (32'd100 << 10) | 32'd200);
    check_points("shadow_only", '{60, 100}, '{630, 200});
    vs = 1'b1;
    tick();
    vs = 1'b0;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 5'd19; wr_if.wr_data = 32'd10;
    #1;
    r0 = wr_if.wr_ready;
    @(posedge vga_clk);
    #1;
    model_commit();
    fd = frame_done;
    r1 = wr_if.wr_ready;
    @(posedge vga_clk);
    #1;
    model_write(19, 32'd10);
    wr_if.wr_valid = 1'b0;
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL hold_ready_commit got=%b exp=0", r0); end
    total++; if (r1 !== 1'b1) begin bad++; $display("FAIL hold_ready_after got=%b exp=1", r1); end
    total++; if (fd !== 1'b1) begin bad++; $display("FAIL hold_frame_done got=%b exp=1", fd); end
    check_points("hold_pre", '{400, 10, 100}, '{0, 0, 200});
    test_commit_check("hold2");
    check_points("hold_post", '{10, 400}, '{0, 0});
    do_read(10, 0, 1'b0, p, pv);
    total++; if (p !== 1'b0 || pv !== 1'b0) begin bad++; $display("FAIL idle_read got px=%b pv=%b exp 0 0", p, pv); end
  endtask

  task automatic test_random();
    logic p, pv, e, rc, f1, f2;
    int r, c, sel;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 1) begin
        d = $urandom();
        do_write(5'($urandom_range(0, 31)), d);
      end else if (sel == 2) begin
        d = ($urandom_range(0, 470) << 10) | $urandom_range(0, 639);
        do_write(5'd18, d);
      end else if (sel == 3) begin
        do_commit(rc, f1, f2);
        total++;
        if (rc !== 1'b0 || f1 !== 1'b1 || f2 !== 1'b0) begin
          bad++;
          $display("FAIL rand_commit got ready=%b fd=%b%b exp 0 10", rc, f1, f2);
        end
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          r = a_sy + int'($urandom_range(0, 19)) - 2;
          c = a_sx + int'($urandom_range(0, 19)) - 2;
        end else begin
          r = a_gy + int'($urandom_range(0, 11)) - 2;
          c = int'($urandom_range(0, 639));
        end
        if (r < 0) r = 0;
        if (r > 479) r = 479;
        if (c < 0) c = 0;
        if (c > 639) c = 639;
        do_read(r, c, 1'b1, p, pv);
        e = model_px(r, c);
        total++;
        if (p !== e || pv !== 1'b1) begin
          bad++;
          $display("FAIL rand_read (%0d,%0d) got px=%b pv=%b exp px=%b pv=1", r, c, p, pv, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic p, pv;
    do_write(5'd18, (32'd200 << 10) | 32'd300);
    do_write(5'd10, 32'hFFFF_FFFF);
    test_commit_check("pre_rst");
    rdn = 1'b0; row_addr = 9'd200; col_addr = 10'd300; rst = 1'b1;
    tick();
    total++; if (px !== 1'b0 || px_valid !== 1'b0) begin bad++; $display("FAIL rst_mid got px=%b pv=%b exp 0 0", px, px_valid); end
    rst = 1'b0; rdn = 1'b1;
    model_clear();
    tick();
    total++; if (px !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b exp=0", px); end
    do_read(200, 300, 1'b1, p, pv);
    total++; if (p !== model_px(200, 300) || pv !== 1'b1) begin bad++; $display("FAIL rst_mid_cleared got px=%b pv=%b exp px=%b pv=1", p, pv, model_px(200, 300)); end
  endtask

  task automatic test_border();
    check_points("border", '{0, 479, 5, 5, 5}, '{5, 5, 0, 639, 5});
  endtask

  initial begin
    test_reset();
    test_ground();
    test_sprite();
    test_clip();
    test_shadow_hold();
    test_random();
    test_reset_mid();
    test_border();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_src.md
Name: vga_pixel_src

Overview:
Pixel source that answers the VGA timing generator's pixel-RAM reads (rdn, row_addr, col_addr) with a 1-bit monochrome pixel, where 1 = black and 0 = white.
- Each frame is composed from two layers: a 320-bit ground strip (2x horizontal scale) and one 16x16 sprite.
- Game logic writes shadow registers through a valid/ready port.
- Shadow registers are committed to the active set only at vertical sync, so the displayed frame never tears.

Parameters:
GROUND_H, 8, ground strip height in lines
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows

Ports:
vga_clk  in  1  25 MHz pixel clock
rst  in  1  synchronous reset, active-high
rdn  in  1  pixel read request, active low (from VGA timing block)
row_addr  in  9  pixel row, 0..479
col_addr  in  10  pixel column, 0..639
vs  in  1  vertical sync from VGA timing block (low during lines 0-1)
wr_valid  in  1  game-side write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_addr  in  5  register word address
wr_data  in  32  write data
px  out  1  pixel, 1 = black
px_valid  out  1  px corresponds to a read issued the previous cycle
frame_done  out  1  one-cycle pulse after each commit

Behaviour:
- Reset (rst=1 at a vga_clk edge) clears the following to 0:
  - all shadow and active registers;
  - px, px_valid, frame_done, wr_ready;
  - the internal vs_q.
- wr_ready is 1 from the first cycle after reset. It goes low only in the commit cycle.
- Write address map (shadow registers; the write takes effect at the edge where wr_valid & wr_ready):
  - 0-9: ground word i. Bit j covers ground bit 32i+j, which maps to columns 64i+2j and 64i+2j+1.
  - 10-17: sprite rows. Word k: [15:0] = row 2(k-10), [31:16] = row 2(k-10)+1. Bit 15 is the leftmost pixel.
  - 18: sprite_x = [9:0], sprite_y = [18:10].
  - 19: ground_y = [8:0].
  - 20-31: accepted, data discarded.
- Commit:
  - vs_q <= vs every cycle.
  - Commit cycle = cycle with vs_q=1 and vs=0. In it, active <= shadow for every register in one edge, and wr_ready=0 (combinational from the same condition).
  - frame_done=1 for exactly the next cycle.
  - No commit occurs at reset release, even if vs=0 (vs_q starts at 0).
- Pixel path, latency 1:
  - Each cycle: px_valid <= ~rdn; px <= ~rdn & hit.
  - With rdn=1, px=0 on the next cycle.
  - hit = ground_hit | sprite_hit, computed from active registers only.
- ground_hit:
  - row_addr in [ground_y, ground_y+GROUND_H-1], compared at 10 bits so there is no 9-bit wrap.
  - and ground bit col_addr[9:1] is 1.
  - No hit if ground_y+GROUND_H-1 > 479 for rows beyond 479. This is naturally satisfied since row_addr ≤ 479.
- sprite_hit:
  - dx = col_addr - sprite_x (10-bit unsigned wrap); dy = row_addr - sprite_y (9-bit unsigned wrap).
  - Hit if dx<16 and dy<16 and bitmap[dy][15-dx].
  - The wrap rejects pixels left of/above the sprite. A sprite extending past col 639 or row 479 is clipped; no wrap onto the opposite edge.
- Writes during visible lines modify shadow only; the display is unaffected until the next commit.
- A repeated write to the same address before a commit: the last write wins.
- Reset mid-frame: registers are cleared; px=0 until rdn is sampled low again after reset.

Optional Feature:
VGA_PX_BORDER_EN:
- Defined: px is forced to 1 (with px_valid=1) when rdn=0 and row_addr∈{0, V_ACTIVE-1} or col_addr∈{0, H_ACTIVE-1}. This gives a 1-pixel black frame for monitor alignment.
- Undefined: no border logic; px is exactly as above.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults;
  - the write address map constants (GND_BASE=0, SPR_BASE=10, POS_ADDR=18, GY_ADDR=19);
  - the sprite size constant SPR_DIM=16.
- One sub-module, vga_sprite_hit: combinational dx/dy/window check plus bitmap bit select. Inputs are row, col, position and bitmap; output is hit.

Test Plan:
1. Reset, then idle with rdn=1 → px=0, px_valid=0, wr_ready=1, frame_done=0; no frame_done pulse at reset release even with vs=0.
2. Write word 0 = 0x0000_0001 and addr 19 = 400, then toggle vs 1→0. After that, reads at row 400, col 0 and col 1 give px=1; row 400 col 2 gives px=0; row 408 col 0 gives px=0; frame_done is high for exactly 1 cycle.
3. Write sprite row 0 = 0x8001 (word 10 = 0x0000_8001) and pos (x=100, y=50), then commit → (50,100)=1, (50,115)=1, (50,101)=0, (50,99)=0, (49,100)=0.
4. Sprite at x=630, row 0 = 0xFFFF, commit → cols 630-639 on row y are black; row y+1 col 0 is white (no wrap).
5. Write a new pos mid-frame with no vs edge → reads still show the old position. Hold wr_valid across the commit cycle → wr_ready=0 that cycle, and the write completes the next cycle.
6. With VGA_PX_BORDER_EN defined, reads at (0,5), (479,5), (5,0) and (5,639) give px=1 and (5,5) gives px=0; without the macro, all five give px=0 after reset.
